// File: rtl/mc_ctrl.sv
// Multicycle LEGv8 control FSM: 3-5 cycles per instruction, plus one per mem_ready-low cycle in MEM_RD/MEM_WR.
// Backpressure: mem_ready low holds MEM_RD/MEM_WR (WAIT_EN=1); HALT is left only through reset.
module mc_ctrl #(
    parameter int OPC_W   = 11,
    parameter int CNT_W   = 32,
    parameter bit WAIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             reg2loc,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             halt,
    output logic             inst_done,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [3:0]       state
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] FETCH    = 4'd1;
    localparam logic [3:0] DECODE   = 4'd2;
    localparam logic [3:0] MEM_ADDR = 4'd3;
    localparam logic [3:0] MEM_RD   = 4'd4;
    localparam logic [3:0] MEM_WB   = 4'd5;
    localparam logic [3:0] MEM_WR   = 4'd6;
    localparam logic [3:0] R_EXEC   = 4'd7;
    localparam logic [3:0] R_WB     = 4'd8;
    localparam logic [3:0] CBZ      = 4'd9;
    localparam logic [3:0] B_JMP    = 4'd10;
    localparam logic [3:0] HALT     = 4'd15;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]  cur_state;
    logic [3:0]  nxt_state;
    logic        is_load_q;
    logic [10:0] opc;
    logic        is_r;
    logic        is_ld;
    logic        is_st;
    logic        is_cbz;
    logic        is_b;
    logic        mem_hold;

    assign opc      = opcode[10:0];
    assign state    = cur_state;
    assign mem_hold = WAIT_EN && !mem_ready;

    always_comb begin
        is_r   = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_ORR);
        is_ld  = (opc == OP_LDUR);
        is_st  = (opc == OP_STUR);
        is_cbz = (opc[10:3] == 8'b10110100);
        is_b   = (opc[10:5] == 6'b000101);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
            is_load_q <= 1'b0;
            inst_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == DECODE)
                is_load_q <= is_ld;
            if (inst_done)
                inst_cnt <= inst_cnt + CNT_ONE;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        reg2loc    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halt       = 1'b0;
        inst_done  = 1'b0;
        case (cur_state)
            IDLE: nxt_state = FETCH;
            FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
                nxt_state = DECODE;
            end
            DECODE: begin
                // ALUOut captures PC + offset<<2 here so CBZ/B can use it next cycle
                alu_src_b = 2'b11;
                reg2loc   = is_st || is_cbz;
                if (is_r)
                    nxt_state = R_EXEC;
                else if (is_ld || is_st)
                    nxt_state = MEM_ADDR;
                else if (is_cbz)
                    nxt_state = CBZ;
                else if (is_b)
                    nxt_state = B_JMP;
                else
                    nxt_state = HALT;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = is_load_q ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                if (!mem_hold)
                    nxt_state = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                inst_done  = 1'b1;
                nxt_state  = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                reg2loc   = 1'b1;
                if (!mem_hold) begin
                    inst_done = 1'b1;
                    nxt_state = FETCH;
                end
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt_state = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                alu_op    = 2'b10;
                inst_done = 1'b1;
                nxt_state = FETCH;
            end
            CBZ: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                reg2loc   = 1'b1;
                pc_src    = 2'b10;
                pc_write  = zero;
                inst_done = 1'b1;
                nxt_state = FETCH;
            end
            B_JMP: begin
                pc_src    = 2'b10;
                pc_write  = 1'b1;
                inst_done = 1'b1;
                nxt_state = FETCH;
            end
            HALT: halt = 1'b1;
            default: nxt_state = IDLE;
        endcase
    end

endmodule
